// File: rtl/apb_master_bridge.sv
// Single-outstanding APB3 initiator: one valid/ready command becomes one APB
// transfer and one response, with an optional wait-state timeout.
module apb_master_bridge #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 16,
    parameter int TO_CNT_W       = 8
) (
    input  logic              pClk,
    input  logic              pReset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              rsp_timeout,
    output logic              pSel,
    output logic              pEnable,
    output logic              pWrite,
    output logic [ADDR_W-1:0] pAddr,
    output logic [DATA_W-1:0] pWdata,
    input  logic              pReady,
    input  logic [DATA_W-1:0] pRdata,
    input  logic              pSlvErr
);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    localparam bit                TO_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [TO_CNT_W-1:0] TO_LAST = TO_CNT_W'(TO_EN ? TIMEOUT_CYCLES - 1 : 0);

    state_t              state_q;
    logic [TO_CNT_W-1:0] to_cnt_q;
    logic                psel_q;
    logic                penable_q;
    logic                pwrite_q;
    logic [ADDR_W-1:0]   paddr_q;
    logic [DATA_W-1:0]   pwdata_q;
    logic                rsp_valid_q;
    logic [DATA_W-1:0]   rsp_rdata_q;
    logic                rsp_err_q;
    logic                rsp_timeout_q;

    always_ff @(posedge pClk or negedge pReset) begin
        if (!pReset) begin
            state_q       <= IDLE;
            to_cnt_q      <= '0;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            pwrite_q      <= 1'b0;
            paddr_q       <= '0;
            pwdata_q      <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cmd_valid) begin
                        pwrite_q  <= cmd_write;
                        paddr_q   <= cmd_addr;
                        pwdata_q  <= cmd_write ? cmd_wdata : '0;
                        psel_q    <= 1'b1;
                        penable_q <= 1'b0;
                        state_q   <= SETUP;
                    end
                end
                SETUP: begin
                    penable_q <= 1'b1;
                    to_cnt_q  <= '0;
                    state_q   <= ACCESS;
                end
                ACCESS: begin
                    // pReady wins over a timeout landing in the same cycle.
                    if (pReady) begin
                        psel_q        <= 1'b0;
                        penable_q     <= 1'b0;
                        rsp_valid_q   <= 1'b1;
                        rsp_rdata_q   <= (!pwrite_q && !pSlvErr) ? pRdata : '0;
                        rsp_err_q     <= pSlvErr;
                        rsp_timeout_q <= 1'b0;
                        state_q       <= RESP;
                    end else if (TO_EN && (to_cnt_q == TO_LAST)) begin
                        psel_q        <= 1'b0;
                        penable_q     <= 1'b0;
                        rsp_valid_q   <= 1'b1;
                        rsp_rdata_q   <= '0;
                        rsp_err_q     <= 1'b1;
                        rsp_timeout_q <= 1'b1;
                        state_q       <= RESP;
                    end else begin
                        to_cnt_q <= to_cnt_q + 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign cmd_ready   = (state_q == IDLE);
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_err     = rsp_err_q;
    assign rsp_timeout = rsp_timeout_q;
    assign pSel        = psel_q;
    assign pEnable     = penable_q;
    assign pWrite      = pwrite_q;
    assign pAddr       = paddr_q;
    assign pWdata      = pwdata_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Scoreboard bench for apb_master_bridge: directed commands push expected
// responses; an independent monitor pops and compares on each handshake.
module tb_apb_master_bridge;

    logic        pClk = 1'b0;
    logic        pReset = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic [31:0] cmd_addr = '0;
    logic [31:0] cmd_wdata = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        rsp_timeout;
    logic        pSel;
    logic        pEnable;
    logic        pWrite;
    logic [31:0] pAddr;
    logic [31:0] pWdata;
    logic        pReady = 1'b0;
    logic [31:0] pRdata = '0;
    logic        pSlvErr = 1'b0;

    apb_master_bridge #(
        .ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(16), .TO_CNT_W(8)
    ) dut (
        .pClk(pClk), .pReset(pReset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
        .pSel(pSel), .pEnable(pEnable), .pWrite(pWrite), .pAddr(pAddr),
        .pWdata(pWdata), .pReady(pReady), .pRdata(pRdata), .pSlvErr(pSlvErr)
    );

    always #5 pClk = ~pClk;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic        to;
    } exp_t;

    exp_t sb[$];
    int   acc_q[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   slv_wait = 0;

    // monitor-owned observations
    int          n_setup = 0, n_access = 0, n_rsp = 0;
    int          acc_edge = 0, hs_edge = 0, last_lat = 0, acc_cnt = 0;
    logic [31:0] s_addr = '0, s_wdata = '0;
    logic        s_write = 1'b0;
    logic        rsp_valid_prev = 1'b0, held = 1'b0;
    logic [31:0] h_rdata = '0;
    logic        h_err = 1'b0, h_to = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    always @(posedge pClk) cyc++;

    // Slave: pReady rises in ACCESS cycle number slv_wait (0-based).
    always @(negedge pClk) begin
        if (pSel && pEnable) begin
            pReady = (acc_cnt == slv_wait);
            acc_cnt++;
        end else begin
            pReady = 1'b0;
            acc_cnt = 0;
        end
    end

    always @(negedge pClk) begin
        if (!pReset) begin
            rsp_valid_prev = 1'b0;
            held = 1'b0;
        end else begin
            check("enable_without_select", {63'd0, pEnable & ~pSel}, 64'd0);
            if (pSel && !pEnable) begin
                n_setup++;
                s_addr = pAddr; s_wdata = pWdata; s_write = pWrite;
            end
            if (pSel && pEnable) begin
                n_access++;
                check("access_addr_stable", pAddr, s_addr);
                check("access_wdata_stable", pWdata, s_wdata);
                check("access_write_stable", pWrite, s_write);
            end
            if (cmd_valid && cmd_ready) begin
                acc_edge = cyc + 1;
                acc_q.push_back(acc_edge);
            end
            if (rsp_valid && !rsp_valid_prev) last_lat = cyc - acc_edge + 1;
            if (rsp_valid && !rsp_ready) begin
                if (held) begin
                    check("hold_rdata", rsp_rdata, h_rdata);
                    check("hold_err_timeout", {rsp_err, rsp_timeout}, {h_err, h_to});
                end
                held = 1'b1;
                h_rdata = rsp_rdata; h_err = rsp_err; h_to = rsp_timeout;
            end else begin
                held = 1'b0;
            end
            if (rsp_valid && rsp_ready) begin
                hs_edge = cyc + 1;
                n_rsp++;
                if (sb.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_response actual=0x%0h required=none", rsp_rdata);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("rsp_rdata", rsp_rdata, e.rdata);
                    check("rsp_err", rsp_err, e.err);
                    check("rsp_timeout", rsp_timeout, e.to);
                end
            end
            rsp_valid_prev = rsp_valid;
        end
    end

    task automatic wait_accept(input string name);
        int n = 0;
        do begin
            @(negedge pClk);
            n++;
        end while (!cmd_ready && n < 100);
        checks++;
        if (!cmd_ready) begin
            failures++;
            $display("FAIL %s actual=no_accept required=accept_within_100", name);
        end
        @(posedge pClk);
        #1;
    endtask

    task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [31:0] er, input logic ee, input logic et);
        sb.push_back('{er, ee, et});
        cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_valid = 1'b1;
        wait_accept("accept");
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while ((sb.size() != 0 || !cmd_ready) && n < 300) begin
            @(negedge pClk);
            n++;
        end
        checks++;
        if (n >= 300) begin
            failures++;
            $display("FAIL %s actual=pending=%0d required=drained", name, sb.size());
            sb.delete();
        end
        @(posedge pClk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int bs, ba, bacc, br, n;

        #1;
        check("reset_psel", pSel, 0);
        check("reset_penable", pEnable, 0);
        check("reset_rsp_valid", rsp_valid, 0);
        check("reset_paddr", pAddr, 0);
        check("reset_pwdata", pWdata, 0);
        check("reset_cmd_ready", cmd_ready, 1);
        repeat (2) @(posedge pClk);
        #1 pReset = 1'b1;
        rsp_ready = 1'b1;

        // Write, zero wait
        slv_wait = 0; bs = n_setup; ba = n_access;
        issue(1'b1, 32'h03, 32'h3, 32'h0, 1'b0, 1'b0);
        wait_done("write_zero_wait");
        check("w0_setup_cycles", n_setup - bs, 1);
        check("w0_access_cycles", n_access - ba, 1);
        check("w0_pwrite", s_write, 1);
        check("w0_paddr", s_addr, 32'h03);
        check("w0_pwdata", s_wdata, 32'h3);
        check("w0_latency", last_lat, 3);

        // Read with three wait states
        slv_wait = 3; pRdata = 32'hA5; bs = n_setup; ba = n_access;
        issue(1'b0, 32'h01, 32'hFFFF_FFFF, 32'hA5, 1'b0, 1'b0);
        wait_done("read_waits");
        check("rd_access_cycles", n_access - ba, 4);
        check("rd_pwdata_zero", s_wdata, 0);
        check("rd_pwrite", s_write, 0);
        check("rd_latency", last_lat, 6);

        // Timeout with pReady stuck low
        slv_wait = 1000; pRdata = 32'hDEAD_BEEF; ba = n_access;
        issue(1'b0, 32'h02, 32'h0, 32'h0, 1'b1, 1'b1);
        wait_done("timeout");
        check("to_access_cycles", n_access - ba, 16);

        // pReady on the 16th ACCESS cycle completes normally
        slv_wait = 15; pRdata = 32'h5A; ba = n_access;
        issue(1'b0, 32'h02, 32'h0, 32'h5A, 1'b0, 1'b0);
        wait_done("ready_at_last_count");
        check("last_access_cycles", n_access - ba, 16);

        // Slave error with response back-pressure and a queued second command
        slv_wait = 0; pSlvErr = 1'b1; pRdata = 32'hFF; rsp_ready = 1'b0;
        issue(1'b0, 32'h05, 32'h0, 32'h0, 1'b1, 1'b0);
        sb.push_back('{32'h0, 1'b0, 1'b0});
        cmd_write = 1'b1; cmd_addr = 32'h04; cmd_wdata = 32'h11; cmd_valid = 1'b1;
        n = 0;
        do begin
            @(negedge pClk);
            n++;
        end while (!rsp_valid && n < 50);
        check("bp_rsp_valid_seen", rsp_valid, 1);
        check("bp_cmd_ready_c0", cmd_ready, 0);
        for (int i = 1; i < 5; i++) begin
            @(negedge pClk);
            check("bp_rsp_valid_held", rsp_valid, 1);
            check("bp_cmd_ready_low", cmd_ready, 0);
        end
        @(posedge pClk);
        #1 rsp_ready = 1'b1; pSlvErr = 1'b0; pRdata = 32'h0;
        wait_accept("second_accept");
        cmd_valid = 1'b0;
        check("second_accept_after_handshake", acc_q[$] - hs_edge, 1);
        wait_done("slverr_backpressure");

        // Reset in the middle of ACCESS
        slv_wait = 1000;
        issue(1'b0, 32'h02, 32'h0, 32'h0, 1'b0, 1'b0);
        n = 0;
        do begin
            @(negedge pClk);
            n++;
        end while (!pEnable && n < 20);
        check("mid_reset_in_access", pEnable, 1);
        #2 pReset = 1'b0;
        #1;
        check("async_psel", pSel, 0);
        check("async_penable", pEnable, 0);
        check("async_rsp_valid", rsp_valid, 0);
        check("async_paddr", pAddr, 0);
        sb.delete();
        @(posedge pClk);
        #1 pReset = 1'b1;
        check("post_reset_cmd_ready", cmd_ready, 1);
        slv_wait = 0;
        issue(1'b1, 32'h00, 32'h77, 32'h0, 1'b0, 1'b0);
        wait_done("post_reset_write");
        check("post_reset_paddr", s_addr, 32'h00);
        check("post_reset_pwdata", s_wdata, 32'h77);

        // Back-to-back writes with cmd_valid held high
        bs = n_setup; ba = n_access; br = n_rsp; bacc = acc_q.size();
        cmd_write = 1'b1; cmd_addr = 32'h00; cmd_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cmd_wdata = 32'h100 + i;
            sb.push_back('{32'h0, 1'b0, 1'b0});
            wait_accept("b2b_accept");
        end
        cmd_valid = 1'b0;
        wait_done("back_to_back");
        check("b2b_setups", n_setup - bs, 4);
        check("b2b_accesses", n_access - ba, 4);
        check("b2b_responses", n_rsp - br, 4);
        check("b2b_last_wdata", s_wdata, 32'h103);
        for (int i = 0; i < 3; i++)
            check("b2b_spacing", acc_q[bacc + i + 1] - acc_q[bacc + i], 4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/apb_master_bridge.md
Name: apb_master_bridge

Overview:
- Single-outstanding APB3 initiator that turns a valid/ready command stream into APB transfers on the peripheral bus.
- Used by the host-side sequencer/CPU shim to program and poll the UART register block: TxDbuffer 0x00, RxDbuffer 0x01, UBRR 0x02, ControlReg0 0x03, ControlReg1 0x04, StatusReg 0x05.
- Returns one response per command, carrying read data and an error flag.
- Adds a wait-state timeout so a hung or unmapped slave cannot stall the host.

Parameters:
- ADDR_W, 32, APB address width.
- DATA_W, 32, APB data width.
- TIMEOUT_CYCLES, 16, maximum ACCESS cycles with pReady low before the bridge aborts the transfer. Value 0 disables the timeout.
- TO_CNT_W, 8, timeout counter width. Must be large enough to hold TIMEOUT_CYCLES.

Ports:
- pClk  in  1  clock
- pReset  in  1  reset, asynchronous, active-low
- cmd_valid  in  1  command present
- cmd_ready  out  1  bridge accepts command this cycle
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_W  target address
- cmd_wdata  in  DATA_W  write data
- rsp_valid  out  1  response available
- rsp_ready  in  1  host consumes response
- rsp_rdata  out  DATA_W  read data; 0 for writes and errored transfers
- rsp_err  out  1  pSlvErr sampled high, or timeout
- rsp_timeout  out  1  transfer aborted by timeout
- pSel  out  1  APB select
- pEnable  out  1  APB enable
- pWrite  out  1  APB direction
- pAddr  out  ADDR_W  APB address
- pWdata  out  DATA_W  APB write data
- pReady  in  1  slave ready; tie to 1 for zero-wait slaves
- pRdata  in  DATA_W  slave read data
- pSlvErr  in  1  slave error; tie to 0 if unsupported

Behaviour:
- Reset: async, active-low. All outputs go to 0 immediately, including pAddr and pWdata. State returns to IDLE and the timeout counter clears. A transfer in progress is dropped with no response.
- All outputs are registered, except cmd_ready, which equals (state == IDLE).
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - cmd_ready = 1.
  - When cmd_valid is high, capture write/addr/wdata. pWdata is driven 0 for reads.
  - At that edge pSel=1, pEnable=0; go to SETUP.
- SETUP:
  - Lasts exactly one cycle.
  - At the next edge pEnable=1; go to ACCESS; timeout counter = 0.
- ACCESS:
  - If pReady = 1: sample pSlvErr and, for reads, pRdata.
    - At that edge pSel=0, pEnable=0, rsp_valid=1.
    - rsp_rdata = pRdata if (read && !pSlvErr), else 0.
    - rsp_err = pSlvErr; rsp_timeout = 0.
    - Go to RESP.
  - Else, if TIMEOUT_CYCLES != 0 and counter == TIMEOUT_CYCLES-1: abort.
    - pSel=0, pEnable=0, rsp_valid=1, rsp_err=1, rsp_timeout=1, rsp_rdata=0.
    - Go to RESP.
  - Otherwise the counter increments.
  - pReady high in the same cycle as the final count takes priority: normal completion.
- RESP:
  - rsp_valid and rsp_* are held stable until rsp_ready = 1.
  - At that edge rsp_valid=0; go to IDLE.
  - cmd_ready = 0 throughout, so there are never two outstanding transfers.
- pAddr, pWrite and pWdata are constant from SETUP through the end of ACCESS. They keep their values after the transfer until the next command is accepted.
- Latency with pReady = 1: command accepted at edge T0, pSel high in cycle T0+1, pEnable high in cycle T0+2, rsp_valid high in cycle T0+3. Each wait state adds 1 cycle.
- Minimum command-to-command spacing is 4 cycles when rsp_ready is held at 1.
- A UART-register byte read returns the full DATA_W word; the host uses bits [7:0].
- pSel and pEnable never go high outside SETUP/ACCESS. pEnable never goes high without pSel.

Test Plan:
- Write, zero wait: cmd write addr 0x03 wdata 0x0000_0003, pReady=1, rsp_ready=1.
  - Required: pSel=1/pEnable=0 for 1 cycle, then pSel=1/pEnable=1 for 1 cycle, pWrite=1, pAddr=0x03, pWdata=0x3.
  - rsp_valid 3 cycles after accept, rsp_err=0, rsp_rdata=0.
- Read with waits: cmd read addr 0x01; slave holds pReady=0 for 3 ACCESS cycles, then pReady=1 with pRdata=0x0000_00A5.
  - Required: pEnable high for 4 cycles, pWdata=0, rsp_rdata=0xA5, rsp_valid 6 cycles after accept.
- Timeout: TIMEOUT_CYCLES=16, pReady stuck 0.
  - Required: ACCESS lasts exactly 16 cycles, then pSel/pEnable drop, rsp_err=1, rsp_timeout=1, rsp_rdata=0.
  - Repeat with pReady=1 arriving on the 16th cycle: normal completion, rsp_timeout=0.
- Slave error plus response back-pressure: read addr 0x05 with pSlvErr=1 and pRdata=0xFF at completion; rsp_ready low for 5 cycles.
  - Required: rsp_err=1, rsp_rdata=0, rsp_valid and fields stable for all 5 cycles.
  - cmd_ready=0 with cmd_valid asserted; the second command is accepted only in the cycle after rsp_ready.
- Reset mid-ACCESS: assert pReset low while pEnable=1.
  - Required: pSel, pEnable, rsp_valid and pAddr are 0 immediately, before the next clock edge.
  - After release cmd_ready=1, and a following write to 0x00 completes normally.
- Back-to-back: 4 writes to 0x00 with cmd_valid held high and rsp_ready=1.
  - Required: exactly 4 SETUP/ACCESS pairs spaced 4 cycles apart, 4 responses, no overlap.
